mem_arbiter: RTL

Shares one single-port synchronous 16-bit memory between three requesters: the control unit's instruction fetch, the datapath's load/store path, and the debug/program-loader port. Sits between the control unit/datapath and a unified memory. Each cycle it grants at most one access by fixed priority, with a streak limit that prevents starvation, and routes the registered read data back to the owner.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/mem_arbiter_fixed_prio_arb.sv | 32 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory port identifiers and bus widths used by the
// control unit, datapath and the memory arbiter.
package cpu_pkg;

    // Program counter width; the unified memory is word-addressed by PC values.
    localparam int PC_WIDTH   = 8;
    localparam int ADDR_WIDTH = PC_WIDTH;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_FETCH,
        PORT_DATA,
        PORT_DBG
    } mem_port_t;

    // Port identifier to one-hot request-vector position: [0]=fetch, [1]=data, [2]=debug.
    function automatic logic [2:0] port_onehot(input mem_port_t p);
        logic [2:0] v;
        v = 3'b000;
        case (p)
            PORT_FETCH: v = 3'b001;
            PORT_DATA:  v = 3'b010;
            PORT_DBG:   v = 3'b100;
            default:    v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_fixed_prio_arb.sv
// Combinational three-way fixed-priority selector (debug > data > fetch).
// A masked port is treated as not requesting, letting the next one through.
module fixed_prio_arb
    import cpu_pkg::*;
(
    input  logic [2:0] i_req,   // [0]=fetch, [1]=data, [2]=debug
    input  logic [2:0] i_mask,  // 1 = port excluded this cycle
    output logic [2:0] o_gnt,   // one-hot grant, same bit order as i_req
    output mem_port_t  o_port
);

    logic [2:0] w_eligible;

    assign w_eligible = i_req & ~i_mask;

    // Pick the highest-priority eligible requester.
    always_comb begin
        o_gnt  = 3'b000;
        o_port = PORT_NONE;
        if (w_eligible[2]) begin
            o_gnt  = 3'b100;
            o_port = PORT_DBG;
        end else if (w_eligible[1]) begin
            o_gnt  = 3'b010;
            o_port = PORT_DATA;
        end else if (w_eligible[0]) begin
            o_gnt  = 3'b001;
            o_port = PORT_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for instruction fetch, load/store and the
// debug/loader port. Fixed priority with a streak limit so a busy
// high-priority port cannot starve the others; read data is routed back to
// the port whose read was granted one cycle earlier.
module mem_arbiter
    import cpu_pkg::mem_port_t, cpu_pkg::PORT_NONE, cpu_pkg::PORT_FETCH,
           cpu_pkg::PORT_DATA, cpu_pkg::PORT_DBG, cpu_pkg::port_onehot;
#(
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,      // active low, synchronous

    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,

    input  logic                  x_req,
    input  logic                  x_we,
    input  logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0] x_wdata,
    output logic                  x_gnt,
    output logic                  x_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output mem_port_t             owner
);

    localparam int              SW         = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_BURST);

    logic [2:0]    w_req;
    logic [2:0]    w_mask;
    logic [2:0]    w_gnt;
    logic [2:0]    w_last_oh;
    logic [2:0]    w_resp_oh;
    logic          w_others_req;
    mem_port_t     w_port;

    mem_port_t     r_last_owner;
    mem_port_t     r_resp_owner;
    logic [SW-1:0] r_streak;

    // Requests are ignored entirely while reset is asserted.
    assign w_req        = reset ? {x_req, d_req, f_req} : 3'b000;
    assign w_last_oh    = port_onehot(r_last_owner);
    assign w_others_req = |(w_req & ~w_last_oh);

    // Bench the streak holder only when it has used its burst and someone else waits.
    assign w_mask = ((r_streak == STREAK_MAX) && (|(w_req & w_last_oh)) && w_others_req)
                    ? w_last_oh : 3'b000;

    fixed_prio_arb u_prio (
        .i_req  (w_req),
        .i_mask (w_mask),
        .o_gnt  (w_gnt),
        .o_port (w_port)
    );

    assign f_gnt = w_gnt[0];
    assign d_gnt = w_gnt[1];
    assign x_gnt = w_gnt[2];
    assign owner = w_port;

    // Steer the winner's command onto the memory bus; idle bus is all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_port)
            PORT_FETCH: begin
                mem_en   = 1'b1;
                mem_addr = f_addr;
            end
            PORT_DATA: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            PORT_DBG: begin
                mem_en    = 1'b1;
                mem_we    = x_we;
                mem_addr  = x_addr;
                mem_wdata = x_wdata;
            end
            default: ;
        endcase
    end

    // Track the grant streak and remember which port owns next cycle's read data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_streak     <= '0;
            r_last_owner <= PORT_NONE;
            r_resp_owner <= PORT_NONE;
        end else begin
            r_resp_owner <= (mem_en && !mem_we) ? w_port : PORT_NONE;
            r_last_owner <= w_port;
            if (w_port == PORT_NONE) begin
                r_streak <= '0;
            end else if (w_port != r_last_owner) begin
                r_streak <= SW'(1);
            end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + SW'(1);
            end
        end
    end

    // Responses are suppressed during reset, which also drops a read granted
    // in the cycle just before reset went low.
    assign w_resp_oh = reset ? port_onehot(r_resp_owner) : 3'b000;
    assign f_rvalid  = w_resp_oh[0];
    assign d_rvalid  = w_resp_oh[1];
    assign x_rvalid  = w_resp_oh[2];
    assign rdata     = (|w_resp_oh) ? mem_rdata : '0;

endmodule
